// File: rtl/dag_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dag_unit                                                      |
// | Brief    : Data address generator with I/M/L/B register sets, pre/post   |
// |            modify addressing and circular-buffer wrap. Optional bit-     |
// |            reversed addressing is enabled by defining DAG_BITREV_EN.     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module dag_unit #(
  parameter int DMA_SIZE = 16,
  parameter int DMD_SIZE = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ps_dg_en,
  input  logic                ps_dg_pre,
  input  logic [1:0]          ps_dg_iadd,
  input  logic [1:0]          ps_dg_madd,
  input  logic                ps_dg_wrt_en,
  input  logic                ps_dg_rd_en,
  input  logic [3:0]          ps_dg_radd,
  input  logic [DMD_SIZE-1:0] bc_dt,
`ifdef DAG_BITREV_EN
  input  logic                ps_dg_brev,
`endif
  output logic [DMA_SIZE-1:0] dg_dm_add,
  output logic [DMD_SIZE-1:0] dg_bc_dt
);

  localparam logic [1:0] c_grp_i = 2'b00;
  localparam logic [1:0] c_grp_m = 2'b01;
  localparam logic [1:0] c_grp_l = 2'b10;
  localparam logic [1:0] c_grp_b = 2'b11;

  logic [DMA_SIZE-1:0] r_i [4];
  logic [DMA_SIZE-1:0] r_m [4];
  logic [DMA_SIZE-1:0] r_l [4];
  logic [DMA_SIZE-1:0] r_b [4];
  logic [DMD_SIZE-1:0] r_bc_dt;

  logic [DMA_SIZE-1:0] w_i;
  logic [DMA_SIZE-1:0] w_sum;
  logic [DMA_SIZE-1:0] w_next;
  logic [DMA_SIZE-1:0] w_addr;
  logic [DMA_SIZE-1:0] w_rd_val;
  logic [DMA_SIZE-1:0] w_wr_data;
  logic [1:0]          w_wr_sel;

  // Single-correction circular wrap; the end-of-buffer bound needs one extra bit.
  function automatic logic [DMA_SIZE-1:0] f_wrap(input logic [DMA_SIZE-1:0] x,
                                                 input logic [DMA_SIZE-1:0] len,
                                                 input logic [DMA_SIZE-1:0] base);
    logic [DMA_SIZE:0] lim;
    lim = {1'b0, base} + {1'b0, len};
    if (len == '0)
      return x;
    else if ({1'b0, x} >= lim)
      return x - len;
    else if (x < base)
      return x + len;
    else
      return x;
  endfunction

  assign w_i       = r_i[ps_dg_iadd];
  assign w_sum     = w_i + r_m[ps_dg_madd];
  assign w_next    = f_wrap(w_sum, r_l[ps_dg_iadd], r_b[ps_dg_iadd]);
  assign w_addr    = ps_dg_pre ? w_next : w_i;
  assign w_wr_data = bc_dt[DMA_SIZE-1:0];
  assign w_wr_sel  = ps_dg_radd[1:0];

`ifdef DAG_BITREV_EN
  logic [DMA_SIZE-1:0] w_rev;
  for (genvar gi = 0; gi < DMA_SIZE; gi++) begin : g_brev
    assign w_rev[gi] = w_addr[DMA_SIZE-1-gi];
  end
  assign dg_dm_add = (ps_dg_brev && ps_dg_en) ? w_rev : w_addr;
`else
  assign dg_dm_add = w_addr;
`endif

  always_comb begin
    w_rd_val = '0;
    case (ps_dg_radd[3:2])
      c_grp_i: w_rd_val = r_i[w_wr_sel];
      c_grp_m: w_rd_val = r_m[w_wr_sel];
      c_grp_l: w_rd_val = r_l[w_wr_sel];
      default: w_rd_val = r_b[w_wr_sel];
    endcase
  end

  // Ureg writes are placed after the post-modify update so they take priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        r_i[k] <= '0;
        r_m[k] <= '0;
        r_l[k] <= '0;
        r_b[k] <= '0;
      end
      r_bc_dt <= '0;
    end else begin
      if (ps_dg_en && !ps_dg_pre)
        r_i[ps_dg_iadd] <= w_next;
      if (ps_dg_wrt_en) begin
        case (ps_dg_radd[3:2])
          c_grp_i: r_i[w_wr_sel] <= w_wr_data;
          c_grp_m: r_m[w_wr_sel] <= w_wr_data;
          c_grp_l: r_l[w_wr_sel] <= w_wr_data;
          c_grp_b: begin
            r_b[w_wr_sel] <= w_wr_data;
            r_i[w_wr_sel] <= w_wr_data;
          end
          default: ;
        endcase
      end
      if (ps_dg_rd_en)
        r_bc_dt <= DMD_SIZE'(w_rd_val);
    end
  end

  assign dg_bc_dt = r_bc_dt;

endmodule
`default_nettype wire

// File: tb/tb_dag_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_dag_unit                                                   |
// | Brief    : Self-checking bench for dag_unit (vector table + random model) |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_dag_unit;

  logic        clk;
  logic        reset;
  logic        ps_dg_en;
  logic        ps_dg_pre;
  logic [1:0]  ps_dg_iadd;
  logic [1:0]  ps_dg_madd;
  logic        ps_dg_wrt_en;
  logic        ps_dg_rd_en;
  logic [3:0]  ps_dg_radd;
  logic [15:0] bc_dt;
  logic        ps_dg_brev;
  logic [15:0] dg_dm_add;
  logic [15:0] dg_bc_dt;

  dag_unit #(.DMA_SIZE(16), .DMD_SIZE(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .ps_dg_en     (ps_dg_en),
    .ps_dg_pre    (ps_dg_pre),
    .ps_dg_iadd   (ps_dg_iadd),
    .ps_dg_madd   (ps_dg_madd),
    .ps_dg_wrt_en (ps_dg_wrt_en),
    .ps_dg_rd_en  (ps_dg_rd_en),
    .ps_dg_radd   (ps_dg_radd),
    .bc_dt        (bc_dt),
`ifdef DAG_BITREV_EN
    .ps_dg_brev   (ps_dg_brev),
`endif
    .dg_dm_add    (dg_dm_add),
    .dg_bc_dt     (dg_bc_dt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        en;
    logic        pre;
    logic [1:0]  iadd;
    logic [1:0]  madd;
    logic        wr;
    logic        rd;
    logic [3:0]  radd;
    logic [15:0] dt;
    logic        ca;
    logic [15:0] ea;
    logic        cr;
    logic [15:0] er;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  // Reference register file: index = radd / 4 group, radd % 4 register.
  logic [15:0] mreg [4][4];
  logic [15:0] mrd;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mwrap(input int x, input int len, input int base);
    if (len == 0) return 16'(x);
    if (x >= base + len) return 16'(x - len);
    if (x < base) return 16'(x + len);
    return 16'(x);
  endfunction

  function automatic logic [15:0] mdl_next(input vec_t v);
    int s;
    s = (int'(mreg[0][v.iadd]) + int'(mreg[1][v.madd])) % 65536;
    return mwrap(s, int'(mreg[2][v.iadd]), int'(mreg[3][v.iadd]));
  endfunction

  function automatic logic [15:0] mdl_addr(input vec_t v);
    logic [15:0] a;
    a = v.pre ? mdl_next(v) : mreg[0][v.iadd];
    if (ps_dg_brev && v.en) begin
      logic [15:0] r;
      for (int k = 0; k < 16; k++) r[k] = a[15-k];
      a = r;
    end
    return a;
  endfunction

  task automatic mdl_clear();
    for (int g = 0; g < 4; g++)
      for (int n = 0; n < 4; n++) mreg[g][n] = 16'h0;
    mrd = 16'h0;
  endtask

  function automatic vec_t mk(input logic en, pre, input logic [1:0] iadd, madd,
                              input logic wr, rd, input logic [3:0] radd,
                              input logic [15:0] dt, input logic ca,
                              input logic [15:0] ea, input logic cr,
                              input logic [15:0] er);
    vec_t v;
    v.en = en; v.pre = pre; v.iadd = iadd; v.madd = madd; v.wr = wr; v.rd = rd;
    v.radd = radd; v.dt = dt; v.ca = ca; v.ea = ea; v.cr = cr; v.er = er;
    return v;
  endfunction

  function automatic vec_t vw(input logic [3:0] radd, input logic [15:0] dt);
    return mk(0, 0, 0, 0, 1, 0, radd, dt, 0, 0, 0, 0);
  endfunction
  function automatic vec_t vp(input logic pre, input logic [1:0] n, input logic [15:0] ea);
    return mk(1, pre, n, n, 0, 0, 0, 0, 1, ea, 0, 0);
  endfunction
  function automatic vec_t vr(input logic [3:0] radd, input logic [15:0] er);
    return mk(0, 0, 0, 0, 0, 1, radd, 0, 0, 0, 1, er);
  endfunction

  // One clock: drive at negedge, check address mid-cycle, check read data after the edge.
  task automatic step(input vec_t v, input string tag);
    logic [15:0] exp_a, exp_next, exp_rd;
    @(negedge clk);
    ps_dg_en = v.en; ps_dg_pre = v.pre; ps_dg_iadd = v.iadd; ps_dg_madd = v.madd;
    ps_dg_wrt_en = v.wr; ps_dg_rd_en = v.rd; ps_dg_radd = v.radd; bc_dt = v.dt;
    #1;
    exp_a = mdl_addr(v);
    chk({tag, "_addr_model"}, dg_dm_add, exp_a);
    if (v.ca) chk({tag, "_addr_vec"}, dg_dm_add, v.ea);
    exp_next = mdl_next(v);
    exp_rd   = v.rd ? mreg[v.radd[3:2]][v.radd[1:0]] : mrd;
    @(posedge clk);
    #1;
    if (v.en && !v.pre) mreg[0][v.iadd] = exp_next;
    if (v.wr) begin
      mreg[v.radd[3:2]][v.radd[1:0]] = v.dt;
      if (v.radd[3:2] == 2'b11) mreg[0][v.radd[1:0]] = v.dt;
    end
    mrd = exp_rd;
    chk({tag, "_rd_model"}, dg_bc_dt, mrd);
    if (v.cr) chk({tag, "_rd_vec"}, dg_bc_dt, v.er);
  endtask

  vec_t tbl[$];
  vec_t rv;

  initial begin
    reset = 1'b1; ps_dg_en = 0; ps_dg_pre = 0; ps_dg_iadd = 0; ps_dg_madd = 0;
    ps_dg_wrt_en = 0; ps_dg_rd_en = 0; ps_dg_radd = 0; bc_dt = 0; ps_dg_brev = 0;
    mdl_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_bc_dt", dg_bc_dt, 16'h0);
    chk("reset_dm_add", dg_dm_add, 16'h0);
    @(negedge clk);
    reset = 1'b0;

    // Linear post-modify
    tbl.push_back(vw(4'd0, 16'h0010));
    tbl.push_back(vw(4'd4, 16'h0002));
    tbl.push_back(vp(0, 2'd0, 16'h0010));
    tbl.push_back(vp(0, 2'd0, 16'h0012));
    tbl.push_back(vp(0, 2'd0, 16'h0014));
    tbl.push_back(vr(4'd0, 16'h0016));
    // Circular, positive modify; B write also loads I
    tbl.push_back(vw(4'd13, 16'h0100));
    tbl.push_back(vw(4'd9,  16'h0004));
    tbl.push_back(vw(4'd5,  16'h0001));
    tbl.push_back(vr(4'd1, 16'h0100));
    tbl.push_back(vp(0, 2'd1, 16'h0100));
    tbl.push_back(vp(0, 2'd1, 16'h0101));
    tbl.push_back(vp(0, 2'd1, 16'h0102));
    tbl.push_back(vp(0, 2'd1, 16'h0103));
    tbl.push_back(vp(0, 2'd1, 16'h0100));
    tbl.push_back(vp(0, 2'd1, 16'h0101));
    // Circular, negative modify
    tbl.push_back(vw(4'd14, 16'h0200));
    tbl.push_back(vw(4'd10, 16'h0008));
    tbl.push_back(vw(4'd6,  16'hFFFD));
    tbl.push_back(vw(4'd2,  16'h0201));
    tbl.push_back(vp(0, 2'd2, 16'h0201));
    tbl.push_back(vp(0, 2'd2, 16'h0206));
    tbl.push_back(vp(0, 2'd2, 16'h0203));
    tbl.push_back(vp(0, 2'd2, 16'h0200));
    tbl.push_back(vr(4'd2, 16'h0205));
    // Pre-modify leaves I untouched
    tbl.push_back(vw(4'd3, 16'h0050));
    tbl.push_back(vw(4'd7, 16'h0005));
    tbl.push_back(vp(1, 2'd3, 16'h0055));
    tbl.push_back(vr(4'd3, 16'h0050));
    // Collision: ureg write beats post-modify, read sees old value
    tbl.push_back(vw(4'd0, 16'h0010));
    tbl.push_back(mk(1, 0, 2'd0, 2'd0, 1, 1, 4'd0, 16'h0AAA, 1, 16'h0010, 1, 16'h0010));
    tbl.push_back(vr(4'd0, 16'h0AAA));
    // B write beats post-modify of the same I
    tbl.push_back(mk(1, 0, 2'd1, 2'd1, 1, 0, 4'd13, 16'h0300, 0, 0, 0, 0));
    tbl.push_back(vr(4'd1, 16'h0300));
    tbl.push_back(vr(4'd8, 16'h0000));

    foreach (tbl[k]) step(tbl[k], $sformatf("vec%0d", k));

    // Reset asserted mid-sequence of the circular test
    step(vw(4'd13, 16'h0100), "rst_seq");
    step(vw(4'd9,  16'h0004), "rst_seq");
    step(vw(4'd5,  16'h0001), "rst_seq");
    step(vr(4'd5,  16'h0001), "rst_seq");
    step(vp(0, 2'd1, 16'h0100), "rst_seq");
    @(negedge clk);
    ps_dg_en = 0; ps_dg_wrt_en = 0; ps_dg_rd_en = 0; ps_dg_iadd = 2'd1;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_bc_dt", dg_bc_dt, 16'h0);
    chk("async_rst_dm_add", dg_dm_add, 16'h0);
    mdl_clear();
    @(negedge clk);
    reset = 1'b0;
    step(vp(0, 2'd1, 16'h0000), "post_rst");
    step(vr(4'd13, 16'h0000), "post_rst_b1");

`ifdef DAG_BITREV_EN
    step(vw(4'd0, 16'h0001), "brev");
    ps_dg_brev = 1'b1;
    step(vp(0, 2'd0, 16'h8000), "brev");
    ps_dg_brev = 1'b0;
`endif

    // Random traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      rv = mk($urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
              $urandom_range(0, 1), 4'($urandom_range(0, 15)), 16'($urandom),
              0, 0, 0, 0);
      case (rv.radd[3:2])
        2'b01:   rv.dt = 16'($signed($urandom_range(0, 16)) - 8);
        2'b10:   rv.dt = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom_range(8, 31));
        default: ;
      endcase
      step(rv, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
